// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; sampled only while busy == 0 (states IDLE and DONE)
//   dividend     DW-bit unsigned dividend, captured on an accepted start
//   divisor      VW-bit unsigned divisor, captured on an accepted start
//   busy         high while a division is in progress
//   done         one-cycle pulse: quotient/remainder/div_by_zero are valid
//   quotient     DW-bit unsigned quotient, held until the next completion
//   remainder    VW-bit unsigned remainder, held until the next completion
//   div_by_zero  set with done when the captured divisor was 0; held like quotient

module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] d_reg;     // dividend shift register, MSB consumed first
    logic [VW-1:0] v_reg;     // latched divisor
    logic [VW-1:0] r_reg;     // partial remainder
    logic [DW-2:0] q_acc;     // quotient bits gathered so far
    logic [CW-1:0] count;     // steps already performed

    // The partial remainder is always < divisor, so its top bit is zero
    // between steps and is not stored; the trial value t carries the extra
    // bit so the shifted-in dividend bit never overflows.
    logic [VW:0]   t;
    logic          t_ge;
    logic [VW-1:0] r_next;
    logic [DW-1:0] q_next;
    logic          last_step;

    always_comb begin
        t         = {r_reg, d_reg[DW-1]};
        t_ge      = (t >= {1'b0, v_reg});
        // When t >= v the true difference is < v, so the low VW bits of the
        // modular difference are exact.
        r_next    = t_ge ? (t[VW-1:0] - v_reg) : t[VW-1:0];
        q_next    = {q_acc, t_ge};
        last_step = (count == CW'(DW - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            d_reg       <= '0;
            v_reg       <= '0;
            r_reg       <= '0;
            q_acc       <= '0;
            count       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        d_reg <= dividend;
                        v_reg <= divisor;
                        r_reg <= '0;
                        q_acc <= '0;
                        count <= '0;
                        if (divisor == '0) begin
                            // No iteration needed: report saturated quotient now.
                            state       <= S_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    d_reg <= {d_reg[DW-2:0], 1'b0};
                    r_reg <= r_next;
                    q_acc <= q_next[DW-2:0];
                    count <= count + 1'b1;
                    if (last_step) begin
                        // Results are published only here so they stay stable
                        // (previous result) for the whole run.
                        state       <= S_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider

module tb_seq_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
    } exp_t;

    exp_t sb[$];
    logic [DW-1:0] last_q = '0;
    logic [VW-1:0] last_r = '0;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q  = '1;
            e.r  = '0;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = VW'(a % b);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat = number of rising edges since the accepting edge when done is seen.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (lat <= 40) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
            lat++;
        end
        total++;
        bad++;
        $display("FAIL wait_done: no done pulse within 40 cycles");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_exact();
        logic [DW-1:0] as [3] = '{8'd6, 8'd12, 8'd45};
        logic [VW-1:0] bs [3] = '{4'd2, 4'd3, 4'd9};
        int lat;
        bit ok;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(as[i], bs[i]);
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL exact_busy %0d/%0d: busy=%b, want 1", as[i], bs[i], busy);
            end
            wait_done(lat, ok);
            e = sb.pop_front();
            if (ok) begin
                total++;
                if (lat != DW || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL exact %0d/%0d: lat=%0d q=%0d r=%0d dz=%b busy=%b, want lat=%0d q=%0d r=%0d dz=%b busy=0",
                             e.a, e.b, lat, quotient, remainder, div_by_zero, busy, DW, e.q, e.r, e.dz);
                end
                last_q = e.q;
                last_r = e.r;
            end
        end
    endtask

    task automatic test_remainder();
        logic [DW-1:0] as [6] = '{8'd200, 8'd255, 8'd1, 8'd0, 8'd3, 8'd255};
        logic [VW-1:0] bs [6] = '{4'd7, 4'd15, 4'd1, 4'd5, 4'd4, 4'd1};
        int lat;
        bit ok;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue(as[i], bs[i]);
            wait_done(lat, ok);
            e = sb.pop_front();
            if (ok) begin
                total++;
                if (lat != DW || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
                    bad++;
                    $display("FAIL remainder %0d/%0d: lat=%0d q=%0d r=%0d dz=%b, want lat=%0d q=%0d r=%0d dz=%b",
                             e.a, e.b, lat, quotient, remainder, div_by_zero, DW, e.q, e.r, e.dz);
                end
                last_q = e.q;
                last_r = e.r;
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        bit ok;
        exp_t e;
        issue(8'd17, 4'd0);
        wait_done(lat, ok);
        e = sb.pop_front();
        if (ok) begin
            total++;
            if (lat != 0 || busy !== 1'b0 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
                bad++;
                $display("FAIL div_zero: lat=%0d busy=%b q=%h r=%0d dz=%b, want lat=0 busy=0 q=%h r=%0d dz=%b",
                         lat, busy, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
            end
            last_q = e.q;
            last_r = e.r;
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 8'hFF) begin
            bad++;
            $display("FAIL div_zero_hold: done=%b dz=%b q=%h, want done=0 dz=1 q=ff", done, div_by_zero, quotient);
        end
        issue(8'd6, 4'd2);
        wait_done(lat, ok);
        e = sb.pop_front();
        if (ok) begin
            total++;
            if (div_by_zero !== 1'b0 || quotient !== e.q || remainder !== e.r) begin
                bad++;
                $display("FAIL div_zero_clear: dz=%b q=%0d r=%0d, want dz=0 q=%0d r=%0d",
                         div_by_zero, quotient, remainder, e.q, e.r);
            end
            last_q = e.q;
            last_r = e.r;
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        bit ok;
        exp_t e;
        issue(8'd45, 4'd9);
        repeat (2) @(negedge clk);
        dividend = 8'd9;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || quotient !== last_q || remainder !== last_r) begin
            bad++;
            $display("FAIL run_hold: busy=%b q=%0d r=%0d, want busy=1 q=%0d r=%0d",
                     busy, quotient, remainder, last_q, last_r);
        end
        wait_done(lat, ok);
        e = sb.pop_front();
        if (ok) begin
            total++;
            if (lat != DW - 3 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
                bad++;
                $display("FAIL ignore_start: lat=%0d q=%0d r=%0d dz=%b, want lat=%0d q=%0d r=%0d dz=%b",
                         lat, quotient, remainder, div_by_zero, DW - 3, e.q, e.r, e.dz);
            end
            last_q = e.q;
            last_r = e.r;
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignore_no_queue: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ok;
        exp_t e;
        issue(8'd200, 4'd7);
        wait_done(lat, ok);
        e = sb.pop_front();
        if (ok) begin
            total++;
            if (quotient !== e.q || remainder !== e.r || busy !== 1'b0) begin
                bad++;
                $display("FAIL b2b_first: q=%0d r=%0d busy=%b, want q=%0d r=%0d busy=0",
                         quotient, remainder, busy, e.q, e.r);
            end
        end
        dividend = 8'd6;
        divisor  = 4'd2;
        start    = 1'b1;
        sb.push_back(model(8'd6, 4'd2));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        wait_done(lat, ok);
        e = sb.pop_front();
        if (ok) begin
            total++;
            if (lat != DW || quotient !== e.q || remainder !== e.r) begin
                bad++;
                $display("FAIL b2b_second: lat=%0d q=%0d r=%0d, want lat=%0d q=%0d r=%0d",
                         lat, quotient, remainder, DW, e.q, e.r);
            end
            last_q = e.q;
            last_r = e.r;
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit ok;
        bit saw_done;
        exp_t e;
        issue(8'd200, 4'd7);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_run: busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL reset_no_done: done pulse seen after abort, want none");
        end
        issue(8'd45, 4'd9);
        wait_done(lat, ok);
        e = sb.pop_front();
        if (ok) begin
            total++;
            if (lat != DW || quotient !== e.q || remainder !== e.r) begin
                bad++;
                $display("FAIL after_reset: lat=%0d q=%0d r=%0d, want lat=%0d q=%0d r=%0d",
                         lat, quotient, remainder, DW, e.q, e.r);
            end
        end
    endtask

    task automatic test_sweep();
        int lat;
        bit ok;
        exp_t e;
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        for (int i = 0; i < 300; i++) begin
            a = DW'($urandom_range(0, 255));
            b = VW'($urandom_range(0, 15));
            issue(a, b);
            wait_done(lat, ok);
            e = sb.pop_front();
            if (ok) begin
                total++;
                if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
                    bad++;
                    $display("FAIL sweep %0d/%0d: q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                             a, b, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
                end
                if (e.dz == 1'b0) begin
                    total++;
                    if ((int'(quotient) * int'(b) + int'(remainder)) != int'(a) || int'(remainder) >= int'(b)) begin
                        bad++;
                        $display("FAIL sweep_invariant %0d/%0d: q=%0d r=%0d violate q*b+r==a, r<b",
                                 a, b, quotient, remainder);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_remainder();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
